// File: rtl/burst_accum.sv
// Sums a burst of LEN unsigned samples into a wider total; out_valid rises on the edge of the LEN-th transfer.
// Backpressure: in_ready only in ACC; the total is held stable in DONE until out_ready.
module burst_accum #(
    parameter int WIDTH     = 16,
    parameter int LEN       = 4,
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [7:0]           count
);

    if (LEN < 1 || LEN > 255 || ACC_WIDTH < WIDTH + $clog2(LEN)) begin : g_param_err
        $error("burst_accum: illegal LEN/ACC_WIDTH combination");
    end

    localparam logic [7:0] LEN_C = 8'(LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ACC  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic                 xfer;
    logic                 last_xfer;

    assign acc_sum   = acc + ACC_WIDTH'(in_data);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = (count == LEN_C - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ACC;
                        acc      <= '0;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (xfer) begin
                        acc   <= acc_sum;
                        count <= count + 8'd1;
                        if (last_xfer) begin
                            state     <= S_DONE;
                            out_data  <= acc_sum;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Clearing here keeps IDLE at acc==0/count==0 between bursts.
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    acc       <= '0;
                    count     <= '0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef FORMAL
    // count<=LEN is not 1-inductive on its own; it needs reachability from reset.
    always @* begin
        assert (count <= LEN_C);
        assert (!(in_ready && out_valid));
        if (out_valid) assert (count == LEN_C);
        if (state == S_IDLE) assert (count == 8'd0);
        if (state == S_IDLE) assert (acc == '0);
    end
`endif

endmodule

// File: doc/burst_accum.md
Name: burst_accum

Overview:
- Downstream consumer of the 16-bit add/sub datapath result.
- Collects a burst of LEN results over a valid/ready handshake and sums them into a wider accumulator.
- Presents the total on an output handshake, then returns to idle.
- Carries embedded immediate assertions so the block doubles as a model-checking sample whose properties need reachability reasoning, not plain k-induction.

Parameters:
- WIDTH, 16, width of each incoming sample.
- LEN, 4, samples per burst; legal range 1..255.
- ACC_WIDTH, 24, accumulator width; must be >= WIDTH + clog2(LEN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- in_valid  input  1  upstream sample valid.
- in_data  input  WIDTH  upstream sample (datapath result, unsigned).
- in_ready  output  1  block accepts a sample this cycle.
- out_valid  output  1  burst total valid.
- out_data  output  ACC_WIDTH  burst total.
- out_ready  input  1  downstream accepts total.
- busy  output  1  high in ACC or DONE.
- count  output  8  samples accepted in the current burst.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=0, count=0.
  - in_ready=0, out_valid=0, out_data=0, busy=0.
  - Reset mid-burst discards partial sum; no output is produced.
- States: IDLE, ACC, DONE; 2-bit encoding; unused code returns to IDLE on the next edge.
- IDLE:
  - in_ready=0.
  - start=1 → ACC next cycle; acc<=0, count<=0.
  - in_valid is ignored in IDLE.
- ACC:
  - in_ready=1.
  - Transfer occurs when in_valid&&in_ready: acc<=acc+zero-extended in_data, count<=count+1.
  - On the transfer that makes count==LEN → DONE next cycle; out_data<=final sum (includes that sample).
  - in_valid low: hold state, no change.
  - start ignored.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data stable while out_valid && !out_ready.
  - out_valid&&out_ready → IDLE next cycle; out_valid drops same edge.
  - start asserted in the handoff cycle is ignored; a new start is needed in IDLE.
- Latency: first accepted sample to out_valid = LEN cycles with back-to-back valid (the LEN-th transfer edge raises out_valid).
- Arithmetic:
  - Unsigned, modulo 2^ACC_WIDTH.
  - Parameter rule guarantees no wrap for LEN samples of max value.
  - out_data is registered, never combinational from in_data.
- busy = (state != IDLE).
- count is registered and resets to 0 on entering ACC.
- Embedded assertions, in an always @* block, under `ifdef FORMAL:
  - count <= LEN at all times.
  - !(in_ready && out_valid).
  - out_valid → count==LEN.
  - In IDLE, acc==0 or the last burst has completed; acc is cleared on start, so assert count==0 when state==IDLE.
  - Each assertion holds in every reachable state. The unreachable count>LEN state must not be provable by 1-induction alone; this is deliberate.

Test Plan:
- Reset, then start=1 one cycle; feed in_valid=1 with in_data 1,2,3,4 back-to-back; out_ready=1 → out_valid on cycle 4 after the first transfer, out_data=10, then IDLE, busy=0.
- LEN=4, samples 0xFFFF ×4 → out_data=0x03FFFC (no wrap in 24 bits).
- Stall, part 1: in_valid toggles 1,0,0,1,1,0,1 with data 5 on each valid; count steps 1..4 only on valid cycles; out_data=20.
- Stall, part 2: hold out_ready=0 for 3 cycles → out_valid and out_data stay stable, in_ready=0.
- Assert rst_n=0 asynchronously after 2 accepted samples (mid-clock) → outputs clear immediately with no clock edge; a following burst of 1,1,1,1 yields 4, not including the stale partial sum.
- start pulsed during ACC and during the DONE handoff cycle → no restart, count unaffected, block ends in IDLE; in_valid=1 in IDLE → in_ready stays 0, nothing accumulated.
- Formal run with FORMAL defined, default parameters → all assertions proven by an interpolation/reachability engine; k-induction at low k is expected to report inconclusive on count<=LEN.
